// File: rtl/sim_run_controller_if.sv
// Monitor bundle from the core array into the run controller:
// per-hart fetch PC / retire pulses and the shared data-store bus.
interface sim_run_controller_if #(
  parameter int NUM_HARTS = 2,
  parameter int XLEN      = 32
);
  logic [NUM_HARTS*XLEN-1:0] hart_pc;
  logic [NUM_HARTS-1:0]      hart_retire;
  logic                      st_valid;
  logic [XLEN-1:0]           st_addr;
  logic [XLEN-1:0]           st_data;

  modport master (
    output hart_pc, hart_retire,
    output st_valid, st_addr, st_data
  );

  modport slave (
    input hart_pc, hart_retire,
    input st_valid, st_addr, st_data
  );
endinterface

// File: rtl/sim_run_controller.sv
// Simulation run controller: sequences core reset, counts cycles and
// retirements, and ends the run on tohost, all-harts-halted or timeout.
module sim_run_controller #(
  parameter int              NUM_HARTS      = 2,
  parameter int              XLEN           = 32,
  parameter int              CNT_W          = 32,
  parameter int              RESET_CYCLES   = 2,
  parameter int              HALT_CYCLES    = 8,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 'h1000,
  parameter bit              END_ON_HALT    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       core_rst_n,
  sim_run_controller_if.slave        mon,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 end_cause,
  output logic [XLEN-2:0]            fail_code,
  output logic [NUM_HARTS-1:0]       hart_halted,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_HARTS*CNT_W-1:0] instret_count
);

  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [RW-1:0]   rst_cnt;
  logic [SW-1:0]   stall   [NUM_HARTS];
  logic [XLEN-1:0] prev_pc [NUM_HARTS];

  logic tohost_hit;
  logic halt_all;
  logic timeout_hit;
  logic end_now;

  always_comb begin
    hart_halted = '0;
    for (int i = 0; i < NUM_HARTS; i++)
      hart_halted[i] = (stall[i] >= SW'(HALT_CYCLES));
  end

  always_comb begin
    tohost_hit  = mon.st_valid
                && (mon.st_addr == TOHOST_ADDR)
                && mon.st_data[0];
    halt_all    = END_ON_HALT && (&hart_halted);
    timeout_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
    end_now     = tohost_hit | halt_all | timeout_hit;
    state_d     = state_q;
    unique case (state_q)
      S_RESET: if (rst_cnt == RW'(RESET_CYCLES - 1)) state_d = S_RUN;
      S_RUN:   if (end_now) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt       <= '0;
      core_rst_n    <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      end_cause     <= 2'd0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
      for (int i = 0; i < NUM_HARTS; i++) begin
        stall[i]   <= '0;
        prev_pc[i] <= '0;
      end
    end else if (state_q == S_RESET) begin
      rst_cnt <= rst_cnt + 1'b1;
      if (state_d == S_RUN) core_rst_n <= 1'b1;
    end else if (state_q == S_RUN) begin
      cycle_count <= cycle_count + 1'b1;
      for (int i = 0; i < NUM_HARTS; i++) begin
        if (mon.hart_retire[i]
            && instret_count[i*CNT_W +: CNT_W] != '1)
          instret_count[i*CNT_W +: CNT_W] <=
            instret_count[i*CNT_W +: CNT_W] + 1'b1;
        // A moving PC or a retirement means the hart is alive
        if (mon.hart_pc[i*XLEN +: XLEN] != prev_pc[i]
            || mon.hart_retire[i])
          stall[i] <= '0;
        else if (stall[i] != SW'(HALT_CYCLES))
          stall[i] <= stall[i] + 1'b1;
        prev_pc[i] <= mon.hart_pc[i*XLEN +: XLEN];
      end
      if (end_now) begin
        done <= 1'b1;
        if (tohost_hit) begin
          end_cause <= 2'd1;
          if (mon.st_data == XLEN'(1)) begin
            pass <= 1'b1;
          end else begin
            fail      <= 1'b1;
            fail_code <= mon.st_data[XLEN-1:1];
          end
        end else if (halt_all) begin
          end_cause <= 2'd2;
        end else begin
          fail      <= 1'b1;
          end_cause <= 2'd3;
        end
      end
    end
  end

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: reset sequencing, tohost
// pass/fail, halt detection, timeout priority and async reset.
module tb_sim_run_controller;

  localparam int NH = 2;
  localparam int XL = 32;
  localparam int CW = 32;

  logic clk;
  logic rst_n;

  sim_run_controller_if #(.NUM_HARTS(NH), .XLEN(XL)) bus ();

  logic             core_rst_n, done, pass, fail;
  logic [1:0]       end_cause;
  logic [XL-2:0]    fail_code;
  logic [NH-1:0]    hart_halted;
  logic [CW-1:0]    cycle_count;
  logic [NH*CW-1:0] instret_count;

  logic             core_rst_n2, done2, pass2, fail2;
  logic [1:0]       end_cause2;
  logic [XL-2:0]    fail_code2;
  logic [NH-1:0]    hart_halted2;
  logic [CW-1:0]    cycle_count2;
  logic [NH*CW-1:0] instret_count2;

  sim_run_controller dut (
    .clk(clk), .rst_n(rst_n), .core_rst_n(core_rst_n),
    .mon(bus),
    .done(done), .pass(pass), .fail(fail),
    .end_cause(end_cause), .fail_code(fail_code),
    .hart_halted(hart_halted), .cycle_count(cycle_count),
    .instret_count(instret_count)
  );

  sim_run_controller #(.END_ON_HALT(1'b0)) dut_noh (
    .clk(clk), .rst_n(rst_n), .core_rst_n(core_rst_n2),
    .mon(bus),
    .done(done2), .pass(pass2), .fail(fail2),
    .end_cause(end_cause2), .fail_code(fail_code2),
    .hart_halted(hart_halted2), .cycle_count(cycle_count2),
    .instret_count(instret_count2)
  );

  int total = 0;
  int bad   = 0;
  bit moving;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pc(input logic [XL-1:0] p0,
                        input logic [XL-1:0] p1);
    bus.hart_pc = {p1, p0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.st_valid = 1'b0;
    if (moving)
      set_pc(bus.hart_pc[0 +: XL] + 4, bus.hart_pc[XL +: XL] + 4);
  endtask

  task automatic store(input logic [XL-1:0] a,
                       input logic [XL-1:0] d);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic start_run(input bit chk);
    @(negedge clk);
    rst_n           = 1'b0;
    bus.st_valid    = 1'b0;
    bus.st_addr     = '0;
    bus.st_data     = '0;
    bus.hart_retire = '0;
    #1;
    if (chk) begin
      check("rst_core_rst_n", 64'(core_rst_n), 64'd0);
      check("rst_done", 64'(done), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if (chk) check("seq_edge1_core", 64'(core_rst_n), 64'd0);
    @(posedge clk);
    #1;
    if (chk) begin
      check("seq_edge2_core", 64'(core_rst_n), 64'd1);
      check("seq_cycle0", 64'(cycle_count), 64'd0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    moving = 1'b1;
    set_pc(32'h100, 32'h200);
    bus.st_valid    = 1'b0;
    bus.st_addr     = '0;
    bus.st_data     = '0;
    bus.hart_retire = '0;

    // pass via tohost in RUN cycle 50
    start_run(1'b1);
    repeat (50) step();
    check("pass_pre_done", 64'(done), 64'd0);
    store(32'h1000, 32'h1);
    step();
    check("pass_done", 64'(done), 64'd1);
    check("pass_pass", 64'(pass), 64'd1);
    check("pass_fail", 64'(fail), 64'd0);
    check("pass_cause", 64'(end_cause), 64'd1);
    check("pass_cycles", 64'(cycle_count), 64'd51);
    store(32'h1000, 32'hB);
    repeat (3) step();
    check("frozen_cycles", 64'(cycle_count), 64'd51);
    check("frozen_fail", 64'(fail), 64'd0);
    check("frozen_core", 64'(core_rst_n), 64'd1);

    // fail, after ignored stores
    start_run(1'b0);
    repeat (5) step();
    store(32'h1000, 32'h2);
    step();
    check("ign_even_data", 64'(done), 64'd0);
    store(32'h1004, 32'h1);
    step();
    check("ign_other_addr", 64'(done), 64'd0);
    store(32'h1000, 32'hB);
    step();
    check("fail_done", 64'(done), 64'd1);
    check("fail_fail", 64'(fail), 64'd1);
    check("fail_pass", 64'(pass), 64'd0);
    check("fail_code", 64'(fail_code), 64'd5);
    check("fail_cause", 64'(end_cause), 64'd1);

    // halt: both PCs parked at 0x40, no retire
    moving = 1'b0;
    set_pc(32'h40, 32'h40);
    start_run(1'b0);
    repeat (9) step();
    check("halt_flags", 64'(hart_halted), 64'd3);
    check("halt_pre_done", 64'(done), 64'd0);
    step();
    check("halt_done", 64'(done), 64'd1);
    check("halt_cause", 64'(end_cause), 64'd2);
    check("halt_verdict", 64'({pass, fail}), 64'd0);
    check("halt_cycles", 64'(cycle_count), 64'd10);
    check("noh_flags", 64'(hart_halted2), 64'd3);
    check("noh_done", 64'(done2), 64'd0);
    set_pc(32'h44, 32'h44);
    step();
    check("noh_cleared", 64'(hart_halted2), 64'd0);
    check("halt_frozen", 64'(hart_halted), 64'd3);

    // timeout
    moving = 1'b1;
    start_run(1'b0);
    repeat (999) step();
    check("to_pre_done", 64'(done), 64'd0);
    step();
    check("to_done", 64'(done), 64'd1);
    check("to_fail", 64'(fail), 64'd1);
    check("to_cause", 64'(end_cause), 64'd3);
    check("to_cycles", 64'(cycle_count), 64'd1000);

    // tohost wins over timeout in the last cycle
    start_run(1'b0);
    repeat (999) step();
    store(32'h1000, 32'h1);
    step();
    check("prio_pass", 64'(pass), 64'd1);
    check("prio_fail", 64'(fail), 64'd0);
    check("prio_cause", 64'(end_cause), 64'd1);

    // retire counts then async reset between edges
    start_run(1'b0);
    for (int k = 0; k < 10; k++) begin
      bus.hart_retire = {1'(k < 3), 1'b1};
      step();
    end
    bus.hart_retire = '0;
    step();
    check("instret0", 64'(instret_count[0 +: CW]), 64'd10);
    check("instret1", 64'(instret_count[CW +: CW]), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_core", 64'(core_rst_n), 64'd0);
    check("async_cycles", 64'(cycle_count), 64'd0);
    check("async_instret", 64'(instret_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
